// File: rtl/rv_cluster_mem_arbiter.sv
// Round-robin arbiter between per-hart memory request ports and the single
// memory-controller port. One transaction is in flight at a time. A lock bit
// keeps the grant on one hart so an atomic read-modify-write pair stays together.
module rv_cluster_mem_arbiter #(
    parameter int N_HARTS = 2,
    parameter int ID_W    = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_HARTS-1:0]     req_valid,
    output logic [N_HARTS-1:0]     req_ready,
    input  logic [32*N_HARTS-1:0]  req_addr,
    input  logic [32*N_HARTS-1:0]  req_wdata,
    input  logic [3*N_HARTS-1:0]   req_ctrl,
    input  logic [N_HARTS-1:0]     req_we,
    input  logic [N_HARTS-1:0]     req_lock,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [2:0]             mem_ctrl,
    output logic                   mem_we,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata,
    output logic [N_HARTS-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       rr;
    logic                  lock_active;
    logic                  lock_q;

    logic                  sel_found;
    logic [ID_W-1:0]       sel_idx;
    logic [31:0]           sel_addr;
    logic [31:0]           sel_wdata;
    logic [2:0]            sel_ctrl;
    logic                  sel_we;
    logic                  sel_lock;
    logic [N_HARTS-1:0]    grant_onehot;

    // Pick the next hart: the locked hart only, or the first requester above rr, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (lock_active) begin
            sel_idx = grant_id;
            for (int h = 0; h < N_HARTS; h++) begin
                if (ID_W'(h) == grant_id && req_valid[h]) begin
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (!sel_found && req_valid[h] && h > int'(rr)) begin
                    sel_found = 1'b1;
                    sel_idx   = ID_W'(h);
                end
            end
            for (int h = 0; h < N_HARTS; h++) begin
                if (!sel_found && req_valid[h] && h <= int'(rr)) begin
                    sel_found = 1'b1;
                    sel_idx   = ID_W'(h);
                end
            end
        end
    end

    // Mux out the selected hart's request fields and build the one-hot strobes
    always_comb begin
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_ctrl     = '0;
        sel_we       = 1'b0;
        sel_lock     = 1'b0;
        req_ready    = '0;
        grant_onehot = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (ID_W'(h) == sel_idx) begin
                sel_addr     = req_addr[32*h +: 32];
                sel_wdata    = req_wdata[32*h +: 32];
                sel_ctrl     = req_ctrl[3*h +: 3];
                sel_we       = req_we[h];
                sel_lock     = req_lock[h];
                req_ready[h] = (state == IDLE) && sel_found;
            end
            grant_onehot[h] = (ID_W'(h) == grant_id);
        end
    end

    assign busy = (state != IDLE);

    // Grant, issue to memory, and return the response; a response in the
    // transfer cycle itself skips WAIT_RSP
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr          <= ID_W'(N_HARTS - 1);
            lock_active <= 1'b0;
            lock_q      <= 1'b0;
            grant_id    <= '0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_ctrl    <= '0;
            mem_we      <= 1'b0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id  <= sel_idx;
                        rr        <= sel_idx;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_ctrl  <= sel_ctrl;
                        mem_we    <= sel_we;
                        lock_q    <= sel_lock;
                        mem_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_rvalid) begin
                            rsp_rdata   <= mem_rdata;
                            rsp_valid   <= grant_onehot;
                            lock_active <= lock_q;
                            state       <= IDLE;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        rsp_rdata   <= mem_rdata;
                        rsp_valid   <= grant_onehot;
                        lock_active <= lock_q;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_cluster_mem_arbiter.sv
// Testbench for rv_cluster_mem_arbiter: directed scenarios plus a randomized
// run, checked by a scoreboard fed from a transaction-level arbitration model.
module tb_rv_cluster_mem_arbiter;

    localparam int N  = 2;
    localparam int IW = 3;

    logic              CLK;
    logic              RST;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_addr;
    logic [32*N-1:0]   req_wdata;
    logic [3*N-1:0]    req_ctrl;
    logic [N-1:0]      req_we;
    logic [N-1:0]      req_lock;
    logic              mem_valid;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_ctrl;
    logic              mem_we;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [IW-1:0]     grant_id;
    logic              busy;

    rv_cluster_mem_arbiter #(.N_HARTS(N), .ID_W(IW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .req_we(req_we), .req_lock(req_lock),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl), .mem_we(mem_we),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic        we;
    } txn_t;

    typedef struct {
        int          due;
        int          hart;
        logic [31:0] data;
    } rsp_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    txn_t exp_mem[$];
    rsp_t exp_rsp[$];
    bit   model_free  = 1'b1;
    bit   model_lock  = 1'b0;
    int   model_rr    = N - 1;
    int   model_owner = 0;
    bit   owner_lock  = 1'b0;
    bit   exp_mv      = 1'b0;
    bit   completing  = 1'b0;

    // Observation statistics
    int          gcount[N];
    int          rsp_count[N];
    int          grant_log[$];
    int          last_grant_cyc = 0;
    int          last_rsp_cyc   = 0;
    logic [31:0] last_rsp_rdata = '0;

    // Memory responder knobs
    int          rdy_pct  = 100;
    int          rv_pct   = 100;
    int          same_pct = 0;
    int          junk_pct = 0;
    bit          rdata_fixed_en = 1'b0;
    logic [31:0] rdata_fixed    = '0;
    bit          outstanding    = 1'b0;

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    // Round-robin rule: locked owner only, else first requester after the last winner
    function automatic int pickWinner(input logic [N-1:0] v);
        int w;
        w = -1;
        if (model_lock) begin
            if (v[model_owner]) w = model_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && v[(model_rr + k) % N]) w = (model_rr + k) % N;
            end
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int h, input logic v, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] ctrl,
                                 input logic we, input logic lock);
        req_valid[h]           = v;
        req_addr[32*h +: 32]   = addr;
        req_wdata[32*h +: 32]  = wdata;
        req_ctrl[3*h +: 3]     = ctrl;
        req_we[h]              = we;
        req_lock[h]            = lock;
    endtask

    task automatic dropAll();
        for (int h = 0; h < N; h++) applyStimulus(h, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic doReset();
        tick(1);
        RST = 1'b1;
        dropAll();
        tick(2);
        RST = 1'b0;
    endtask

    task automatic waitGrant(input int h);
        int start;
        start = gcount[h];
        for (int t = 0; t < 300 && gcount[h] == start; t++) tick(1);
        if (gcount[h] == start) checkOutput($sformatf("grant_timeout_h%0d", h), 32'(gcount[h] - start), 32'd1);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    // Memory controller model: random ready, response now or later, junk rvalid while idle
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge CLK);
            #2;
            mem_rdata  = rdata_fixed_en ? rdata_fixed : $urandom;
            mem_rvalid = 1'b0;
            if (RST) begin
                mem_ready   = 1'b0;
                outstanding = 1'b0;
            end else begin
                mem_ready = pct(rdy_pct);
                if (outstanding) begin
                    if (pct(rv_pct)) begin
                        mem_rvalid  = 1'b1;
                        outstanding = 1'b0;
                        exp_rsp.push_back('{due: cyc + 1, hart: model_owner, data: mem_rdata});
                        completing  = 1'b1;
                    end
                end else if (mem_valid && mem_ready) begin
                    if (pct(same_pct)) begin
                        mem_rvalid = 1'b1;
                        exp_rsp.push_back('{due: cyc + 1, hart: model_owner, data: mem_rdata});
                        completing = 1'b1;
                    end else begin
                        outstanding = 1'b1;
                    end
                end else if (!busy && !mem_valid) begin
                    mem_rvalid = pct(junk_pct);
                end
            end
        end
    end

    // Monitor and scoreboard: compares every DUT output each cycle against the model
    initial begin
        int   w;
        txn_t t;
        rsp_t r;
        logic [N-1:0] exp_ready;
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_mem.delete();
                exp_rsp.delete();
                grant_log.delete();
                model_free  = 1'b1;
                model_lock  = 1'b0;
                model_rr    = N - 1;
                model_owner = 0;
                owner_lock  = 1'b0;
                exp_mv      = 1'b0;
                completing  = 1'b0;
                for (int h = 0; h < N; h++) begin
                    gcount[h]    = 0;
                    rsp_count[h] = 0;
                end
            end else begin
                if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
                    r = exp_rsp.pop_front();
                    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1 << r.hart));
                    checkOutput("rsp_rdata", rsp_rdata, r.data);
                end else if (rsp_valid != '0) begin
                    checkOutput("rsp_valid_spurious", 32'(rsp_valid), 32'd0);
                end
                for (int h = 0; h < N; h++) begin
                    if (rsp_valid[h]) begin
                        rsp_count[h]++;
                        last_rsp_cyc   = cyc;
                        last_rsp_rdata = rsp_rdata;
                    end
                end

                checkOutput("busy", 32'(busy), 32'(!model_free));
                checkOutput("mem_valid", 32'(mem_valid), 32'(exp_mv));
                if (mem_valid) begin
                    checkOutput("mem_queue_depth", 32'(exp_mem.size()), 32'd1);
                    if (exp_mem.size() > 0) begin
                        checkOutput("mem_addr", mem_addr, exp_mem[0].addr);
                        checkOutput("mem_wdata", mem_wdata, exp_mem[0].wdata);
                        checkOutput("mem_ctrl", 32'(mem_ctrl), 32'(exp_mem[0].ctrl));
                        checkOutput("mem_we", 32'(mem_we), 32'(exp_mem[0].we));
                        checkOutput("grant_id", 32'(grant_id), 32'(model_owner));
                    end
                    if (mem_ready) begin
                        if (exp_mem.size() > 0) t = exp_mem.pop_front();
                        exp_mv = 1'b0;
                    end
                end

                w = model_free ? pickWinner(req_valid) : -1;
                exp_ready = (w >= 0) ? N'(1 << w) : '0;
                checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
                for (int h = 0; h < N; h++) begin
                    if (req_ready[h]) begin
                        gcount[h]++;
                        grant_log.push_back(h);
                        last_grant_cyc = cyc;
                    end
                end
                if (w >= 0) begin
                    t.addr  = req_addr[32*w +: 32];
                    t.wdata = req_wdata[32*w +: 32];
                    t.ctrl  = req_ctrl[3*w +: 3];
                    t.we    = req_we[w];
                    exp_mem.push_back(t);
                    model_free  = 1'b0;
                    model_rr    = w;
                    model_owner = w;
                    owner_lock  = req_lock[w];
                    exp_mv      = 1'b1;
                end
                if (completing) begin
                    completing = 1'b0;
                    model_free = 1'b1;
                    model_lock = owner_lock;
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        req_valid = '0; req_addr = '0; req_wdata = '0;
        req_ctrl = '0; req_we = '0; req_lock = '0;
        tick(3);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);

        // Single hart-1 load with a one-cycle memory
        $display("[TB] single request on hart 1");
        rdata_fixed_en = 1'b1;
        rdata_fixed    = 32'hDEAD_BEEF;
        doReset();
        applyStimulus(1, 1'b1, 32'h8000_0010, 32'h0, 3'b010, 1'b0, 1'b0);
        waitGrant(1);
        dropAll();
        tick(5);
        checkOutput("single_rsp_count", 32'(rsp_count[1]), 32'd1);
        checkOutput("single_rsp_rdata", last_rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("single_latency", 32'(last_rsp_cyc - last_grant_cyc), 32'd3);
        rdata_fixed_en = 1'b0;

        // Both harts requesting continuously: strict alternation
        $display("[TB] continuous two-hart alternation");
        doReset();
        applyStimulus(0, 1'b1, 32'h0000_1000, 32'h1111_0000, 3'b001, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 32'h0000_2000, 32'h2222_0000, 3'b100, 1'b0, 1'b0);
        for (int t = 0; t < 200 && rsp_count[0] + rsp_count[1] < 8; t++) tick(1);
        checkOutput("alt_rsp_h0", 32'(rsp_count[0]), 32'd4);
        checkOutput("alt_rsp_h1", 32'(rsp_count[1]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (grant_log.size() > i) checkOutput($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));
        end
        dropAll();
        tick(5);

        // Backpressure: memory stalls five cycles in ISSUE
        $display("[TB] backpressure");
        doReset();
        rdy_pct = 0;
        applyStimulus(0, 1'b1, 32'h1234_5670, 32'hA5A5_0001, 3'b010, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 32'h7654_3210, 32'h5A5A_0002, 3'b101, 1'b0, 1'b0);
        waitGrant(0);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick(5);
        checkOutput("bp_mem_valid_held", 32'(mem_valid), 32'd1);
        checkOutput("bp_no_grant_h1", 32'(gcount[1]), 32'd0);
        rdy_pct = 100;
        waitGrant(1);
        dropAll();
        tick(6);

        // Lock: hart 0 locked load then unlocking store before hart 1 gets in
        $display("[TB] lock sequence");
        doReset();
        rdy_pct = 70;
        rv_pct  = 60;
        applyStimulus(1, 1'b1, 32'h0000_0200, 32'h0, 3'b010, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0, 3'b010, 1'b0, 1'b1);
        waitGrant(0);
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'h0000_0005, 3'b010, 1'b1, 1'b0);
        waitGrant(0);
        applyStimulus(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        waitGrant(1);
        dropAll();
        checkOutput("lock_grant_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() >= 3) begin
            checkOutput("lock_grant_0", 32'(grant_log[0]), 32'd0);
            checkOutput("lock_grant_1", 32'(grant_log[1]), 32'd0);
            checkOutput("lock_grant_2", 32'(grant_log[2]), 32'd1);
        end
        rdy_pct = 100;
        rv_pct  = 100;
        tick(8);

        // Response in the same cycle as the transfer
        $display("[TB] same-cycle response");
        doReset();
        same_pct = 100;
        applyStimulus(0, 1'b1, 32'h0000_3000, 32'h0, 3'b000, 1'b0, 1'b0);
        waitGrant(0);
        dropAll();
        tick(6);
        checkOutput("same_rsp_count", 32'(rsp_count[0]), 32'd1);
        checkOutput("same_latency", 32'(last_rsp_cyc - last_grant_cyc), 32'd2);
        same_pct = 0;

        // Reset while waiting for the memory response
        $display("[TB] reset during WAIT_RSP");
        doReset();
        rv_pct = 0;
        applyStimulus(1, 1'b1, 32'h0000_4000, 32'h0, 3'b000, 1'b0, 1'b0);
        waitGrant(1);
        dropAll();
        tick(1);
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        checkOutput("midrst_mem_valid_before", 32'(mem_valid), 32'd0);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        rv_pct = 100;
        applyStimulus(0, 1'b1, 32'h0000_5000, 32'h0, 3'b000, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 32'h0000_6000, 32'h0, 3'b000, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'b01);
        tick(1);
        dropAll();
        tick(6);

        // Randomized traffic with random memory timing and lock bits
        $display("[TB] randomized traffic");
        doReset();
        junk_pct = 20;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) begin
                rdy_pct  = int'($urandom_range(100, 20));
                rv_pct   = int'($urandom_range(100, 20));
                same_pct = int'($urandom_range(60, 0));
            end
            for (int h = 0; h < N; h++) begin
                applyStimulus(h, pct(70), $urandom, $urandom, 3'($urandom), 1'($urandom), pct(25));
            end
            tick(1);
        end
        dropAll();
        rdy_pct  = 100;
        rv_pct   = 100;
        junk_pct = 0;
        for (int t = 0; t < 100 && (busy || exp_rsp.size() > 0); t++) tick(1);
        tick(2);
        checkOutput("drain_busy", 32'(busy), 32'd0);
        checkOutput("drain_rsp_queue", 32'(exp_rsp.size()), 32'd0);
        checkOutput("drain_mem_queue", 32'(exp_mem.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
